// File: rtl/atmega_tim_prescaler.sv
// Shared timer prescaler and T0 front end: free-running 10-bit divider with
// clk8/64/256/1024 ticks, GTCCR (TSM/PSRASY/PSRSYNC) and a synchronised T0 edge detector.
module atmega_tim_prescaler #(
  parameter int BUS_ADDR_IO_LEN = 6,
  parameter int GTCCR_ADDR      = 32'h23,
  parameter int T_SYNC_STAGES   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BUS_ADDR_IO_LEN-1:0] addr_io,
  input  logic                       wr_io,
  input  logic                       rd_io,
  input  logic [7:0]                 bus_io_in,
  output logic [7:0]                 bus_io_out,
  input  logic                       t,
  output logic                       clk8,
  output logic                       clk64,
  output logic                       clk256,
  output logic                       clk1024,
  output logic                       t_fall,
  output logic                       t_rise,
  output logic                       psrasy_rst
);

  localparam logic [BUS_ADDR_IO_LEN-1:0] L_GTCCR_ADDR = BUS_ADDR_IO_LEN'(GTCCR_ADDR);

  logic [9:0]               r_cnt;
  logic                     r_tsm;
  logic                     r_psrasy;
  logic                     r_psrsync;
  logic [T_SYNC_STAGES-1:0] r_sync;
  logic                     r_prev;

  logic w_addr_hit;
  logic w_wr;
  logic w_held;
  logic w_sync_clr;
  logic w_run;
  logic w_t_sync;
  logic w_unused_bus_bits;

  assign w_addr_hit        = (addr_io == L_GTCCR_ADDR);
  assign w_wr              = wr_io & w_addr_hit;
  assign w_held            = r_tsm & r_psrsync;
  assign w_sync_clr        = w_wr & bus_io_in[0];
  // A prescaler clear this cycle wins over any tick that would have fired.
  assign w_run             = ~w_held & ~w_sync_clr;
  assign w_t_sync          = r_sync[T_SYNC_STAGES-1];
  assign w_unused_bus_bits = ^bus_io_in[6:2];

  // GTCCR: PSRASY/PSRSYNC are one-shot unless TSM holds them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tsm     <= 1'b0;
      r_psrasy  <= 1'b0;
      r_psrsync <= 1'b0;
    end else if (w_wr) begin
      r_tsm     <= bus_io_in[7];
      r_psrasy  <= bus_io_in[1];
      r_psrsync <= bus_io_in[0];
    end else if (!r_tsm) begin
      r_psrasy  <= 1'b0;
      r_psrsync <= 1'b0;
    end
  end

  // Divider counter and registered tick strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 10'd0;
      clk8    <= 1'b0;
      clk64   <= 1'b0;
      clk256  <= 1'b0;
      clk1024 <= 1'b0;
    end else begin
      if (w_sync_clr) begin
        r_cnt <= 10'd0;
      end else if (!w_held) begin
        r_cnt <= r_cnt + 10'd1;
      end
      clk8    <= w_run & (r_cnt[2:0] == 3'd7);
      clk64   <= w_run & (r_cnt[5:0] == 6'd63);
      clk256  <= w_run & (r_cnt[7:0] == 8'd255);
      clk1024 <= w_run & (r_cnt == 10'd1023);
    end
  end

  // T0 synchroniser and edge strobes; independent of the prescaler controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      t_rise <= 1'b0;
      t_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[T_SYNC_STAGES-2:0], t};
      r_prev <= w_t_sync;
      t_rise <= w_t_sync & ~r_prev;
      t_fall <= ~w_t_sync & r_prev;
    end
  end

  assign psrasy_rst = r_psrasy;

  // Read mux is OR-combined at SoC level, so drive zero when not selected.
  always_comb begin
    bus_io_out = 8'h00;
    if (!rst && rd_io && w_addr_hit) begin
      bus_io_out = {r_tsm, 5'b00000, r_psrasy, r_psrsync};
    end else begin
      bus_io_out = 8'h00;
    end
  end

endmodule
